// File: rtl/frame_pixel_streamer.sv
// frame_pixel_streamer: reads one IMG_H x IMG_W frame row-major from a
// synchronous-read frame memory and emits it as a tagged valid/ready pixel
// stream. A 2-entry output FIFO absorbs the 1-cycle memory latency and any
// downstream backpressure.
// Optional feature macro: PIX_SIDEBAND_EN adds out_sof/out_eol/out_eof.
module frame_pixel_streamer #(
    parameter int IMG_H  = 28,
    parameter int IMG_W  = 28,
    parameter int DATA_W = 8,
    parameter int ADDR_W = $clog2(IMG_H*IMG_W)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    output logic                      mem_rd_en,
    output logic [ADDR_W-1:0]         mem_rd_addr,
    input  logic [DATA_W-1:0]         mem_rd_data,
    output logic [DATA_W-1:0]         out_pixel,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [$clog2(IMG_W)-1:0]  out_x,
    output logic [$clog2(IMG_H)-1:0]  out_y
`ifdef PIX_SIDEBAND_EN
    ,
    output logic                      out_sof,
    output logic                      out_eol,
    output logic                      out_eof
`endif
);

    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);
    localparam logic [XW-1:0]     X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0]     Y_LAST = YW'(IMG_H - 1);
    localparam logic [ADDR_W-1:0] A_LAST = ADDR_W'(IMG_H*IMG_W - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t state;

    // read-side counters (position of the next read)
    logic [XW-1:0] rx;
    logic [YW-1:0] ry;

    // read in flight: data arrives on mem_rd_data this cycle
    logic          pend;
    logic [XW-1:0] pend_x;
    logic [YW-1:0] pend_y;

    // FIFO second entry; the head lives directly in the out_* registers
    logic              tail_valid;
    logic [DATA_W-1:0] tail_pixel;
    logic [XW-1:0]     tail_x;
    logic [YW-1:0]     tail_y;

    logic       pop;
    logic       last_read;
    logic       last_pop;
    logic [1:0] occ_next;
    logic       head_from_tail;
    logic       head_from_in;
    logic       tail_from_in;

    assign pop       = out_valid && out_ready;
    assign last_read = mem_rd_en && (mem_rd_addr == A_LAST);
    assign last_pop  = pop && (out_x == X_LAST) && (out_y == Y_LAST);

    // Occupancy after this edge counting the in-flight word and this cycle's
    // pop; a new read is only issued if it will find a free slot. Reading the
    // pop here keeps 1 pixel/clk; the path is ready->rd_en, never ->valid.
    always_comb begin
        occ_next  = 2'(out_valid) + 2'(tail_valid) + 2'(pend) - 2'(pop);
        mem_rd_en = (state == S_RUN) && (occ_next < 2'd2);
    end

    // FIFO steering: where the in-flight word lands and whether the head refills
    always_comb begin
        head_from_tail = pop && tail_valid;
        head_from_in   = pend && (pop ? !tail_valid : !out_valid);
        tail_from_in   = pend && !head_from_in;
    end

    // Control FSM with registered busy/done
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state <= S_RUN;
                        busy  <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (last_read) state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (last_pop) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    // Read address generator; increments only, wraps to 0 after the last read
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx          <= '0;
            ry          <= '0;
            mem_rd_addr <= '0;
        end else if (mem_rd_en) begin
            if (last_read) begin
                rx          <= '0;
                ry          <= '0;
                mem_rd_addr <= '0;
            end else begin
                mem_rd_addr <= mem_rd_addr + 1'b1;
                if (rx == X_LAST) begin
                    rx <= '0;
                    ry <= ry + 1'b1;
                end else begin
                    rx <= rx + 1'b1;
                end
            end
        end
    end

    // Track the in-flight read and its tag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend   <= 1'b0;
            pend_x <= '0;
            pend_y <= '0;
        end else begin
            pend <= mem_rd_en;
            if (mem_rd_en) begin
                pend_x <= rx;
                pend_y <= ry;
            end
        end
    end

    // FIFO occupancy flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            tail_valid <= 1'b0;
        end else begin
            if (head_from_tail || head_from_in) out_valid <= 1'b1;
            else if (pop)                       out_valid <= 1'b0;
            if (tail_from_in)                   tail_valid <= 1'b1;
            else if (head_from_tail)            tail_valid <= 1'b0;
        end
    end

    // FIFO payload; head only changes on refill, so it holds while stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_pixel  <= '0;
            out_x      <= '0;
            out_y      <= '0;
            tail_pixel <= '0;
            tail_x     <= '0;
            tail_y     <= '0;
        end else begin
            if (head_from_tail) begin
                out_pixel <= tail_pixel;
                out_x     <= tail_x;
                out_y     <= tail_y;
            end else if (head_from_in) begin
                out_pixel <= mem_rd_data;
                out_x     <= pend_x;
                out_y     <= pend_y;
            end
            if (tail_from_in) begin
                tail_pixel <= mem_rd_data;
                tail_x     <= pend_x;
                tail_y     <= pend_y;
            end
        end
    end

`ifdef PIX_SIDEBAND_EN
    // {sof, eol, eof} for the in-flight word, carried alongside the payload
    logic [2:0] in_sb;
    logic [2:0] tail_sb;

    assign in_sb = {(pend_x == '0) && (pend_y == '0),
                    (pend_x == X_LAST),
                    (pend_x == X_LAST) && (pend_y == Y_LAST)};

    // Sideband follows exactly the same FIFO steering as the payload
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            {out_sof, out_eol, out_eof} <= 3'b000;
            tail_sb                     <= 3'b000;
        end else begin
            if (head_from_tail)    {out_sof, out_eol, out_eof} <= tail_sb;
            else if (head_from_in) {out_sof, out_eol, out_eof} <= in_sb;
            if (tail_from_in)      tail_sb <= in_sb;
        end
    end
`endif

endmodule

// File: tb/tb_frame_pixel_streamer.sv
// tb_frame_pixel_streamer: directed bench for a 4x4 frame with mem[i]=i.
module tb_frame_pixel_streamer;

    localparam int H  = 4;
    localparam int W  = 4;
    localparam int N  = H*W;
    localparam int DW = 8;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          busy;
    logic          done;
    logic          mem_rd_en;
    logic [AW-1:0] mem_rd_addr;
    logic [DW-1:0] mem_rd_data = '0;
    logic [DW-1:0] out_pixel;
    logic          out_valid;
    logic          out_ready;
    logic [1:0]    out_x;
    logic [1:0]    out_y;
`ifdef PIX_SIDEBAND_EN
    logic          out_sof, out_eol, out_eof;
`endif

    frame_pixel_streamer #(.IMG_H(H), .IMG_W(W), .DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .out_pixel(out_pixel), .out_valid(out_valid), .out_ready(out_ready),
        .out_x(out_x), .out_y(out_y)
`ifdef PIX_SIDEBAND_EN
        , .out_sof(out_sof), .out_eol(out_eol), .out_eof(out_eof)
`endif
    );

    always #5 clk = ~clk;

    // frame memory model, 1-cycle read latency
    logic [DW-1:0] mem [N];
    always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    // observed stream
    int reads, accepts, done_cnt, first_valid_cyc, last_acc_cyc, done_cyc;
    int first_rd_addr, gap_err, stab_err, ovr_err;
    logic [DW-1:0] got_pix [$];
    logic [1:0]    got_x   [$];
    logic [1:0]    got_y   [$];
    logic [2:0]    got_sb  [$];
    logic          prev_stall;
    logic [DW+3:0] prev_word;

    // monitor: sampled on the falling edge, away from the active edge
    always @(negedge clk) begin
        if (rst !== 1'b0) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && !(out_valid === 1'b1 && {out_pixel, out_x, out_y} === prev_word))
                stab_err++;
            if (out_valid === 1'b1 && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (mem_rd_en === 1'b1) begin
                if (reads == 0) first_rd_addr = int'(mem_rd_addr);
                reads++;
            end
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                if (accepts > 0 && cyc != last_acc_cyc + 1) gap_err++;
                got_pix.push_back(out_pixel);
                got_x.push_back(out_x);
                got_y.push_back(out_y);
`ifdef PIX_SIDEBAND_EN
                got_sb.push_back({out_sof, out_eol, out_eof});
`else
                got_sb.push_back(3'b000);
`endif
                accepts++;
                last_acc_cyc = cyc;
            end
            if (reads - accepts > 2) ovr_err++;
            if (done === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
            end
            prev_stall = (out_valid === 1'b1) && (out_ready !== 1'b1);
            prev_word  = {out_pixel, out_x, out_y};
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        reads = 0; accepts = 0; done_cnt = 0; first_valid_cyc = -1;
        last_acc_cyc = -1; done_cyc = -1; first_rd_addr = -1;
        gap_err = 0; stab_err = 0; ovr_err = 0; prev_stall = 1'b0;
        got_pix.delete(); got_x.delete(); got_y.delete(); got_sb.delete();
    endtask

    // mode 0: ready always high; mode 1: ready high 30% of cycles
    task automatic set_ready(input int mode);
        out_ready = (mode == 0) ? 1'b1 : ($urandom_range(0, 9) < 3);
    endtask

    task automatic finish_frame(input int mode);
        bit fin = 0;
        for (int k = 0; k < 400 && !fin; k++) begin
            set_ready(mode);
            tick();
            if (done_cnt > 0) fin = 1;
        end
        checks++;
        if (!fin) begin
            errors++;
            $display("FAIL frame_timeout: done seen=%0d, required 1 within 400 cycles", done_cnt);
        end
        out_ready = 1'b1;
        repeat (3) tick();
    endtask

    int start_cyc;

    task automatic run_frame(input int mode);
        clear_mon();
        set_ready(mode);
        start_cyc = cyc;
        start = 1'b1;
        tick();
        start = 1'b0;
        finish_frame(mode);
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; out_ready = 1'b0;
        clear_mon();
        repeat (3) tick();
        checks++;
        if ({busy, done, mem_rd_en, out_valid} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl: busy/done/rd_en/valid=%b, required 0000",
                     {busy, done, mem_rd_en, out_valid});
        end
        checks++;
        if ({mem_rd_addr, out_pixel, out_x, out_y} !== '0) begin
            errors++;
            $display("FAIL reset_data: addr=%0d pixel=%0d x=%0d y=%0d, required all 0",
                     mem_rd_addr, out_pixel, out_x, out_y);
        end
        rst = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_stream();
        run_frame(0);
        checks++;
        if (accepts != N) begin
            errors++;
            $display("FAIL stream_count: got %0d pixels, required %0d", accepts, N);
        end
        for (int i = 0; i < N && i < accepts; i++) begin
            checks++;
            if ({got_pix[i], got_x[i], got_y[i]} !== {DW'(i), 2'(i % W), 2'(i / W)}) begin
                errors++;
                $display("FAIL stream_pix[%0d]: got pixel=%0d x=%0d y=%0d, required %0d (%0d,%0d)",
                         i, got_pix[i], got_x[i], got_y[i], i, i % W, i / W);
            end
        end
        checks++;
        if (first_valid_cyc - start_cyc != 3) begin
            errors++;
            $display("FAIL stream_latency: first valid %0d cycles after start, required 3",
                     first_valid_cyc - start_cyc);
        end
        checks++;
        if (gap_err != 0) begin
            errors++;
            $display("FAIL stream_throughput: %0d gaps in stream, required 0", gap_err);
        end
        checks++;
        if (done_cnt != 1 || done_cyc != last_acc_cyc + 1) begin
            errors++;
            $display("FAIL stream_done: done pulses=%0d at cycle %0d, required 1 at cycle %0d",
                     done_cnt, done_cyc, last_acc_cyc + 1);
        end
`ifdef PIX_SIDEBAND_EN
        for (int i = 0; i < N && i < accepts; i++) begin
            checks++;
            if (got_sb[i] !== {i == 0, (i % W) == W - 1, i == N - 1}) begin
                errors++;
                $display("FAIL sideband[%0d]: sof/eol/eof=%b, required %b", i, got_sb[i],
                         {i == 0, (i % W) == W - 1, i == N - 1});
            end
        end
`endif
    endtask

    task automatic test_random_stall();
        run_frame(1);
        checks++;
        if (accepts != N) begin
            errors++;
            $display("FAIL stall_count: got %0d pixels, required %0d", accepts, N);
        end
        for (int i = 0; i < N && i < accepts; i++) begin
            checks++;
            if ({got_pix[i], got_x[i], got_y[i]} !== {DW'(i), 2'(i % W), 2'(i / W)}) begin
                errors++;
                $display("FAIL stall_pix[%0d]: got pixel=%0d x=%0d y=%0d, required %0d (%0d,%0d)",
                         i, got_pix[i], got_x[i], got_y[i], i, i % W, i / W);
            end
        end
        checks++;
        if (stab_err != 0) begin
            errors++;
            $display("FAIL stall_stable: %0d changes while stalled, required 0", stab_err);
        end
        checks++;
        if (ovr_err != 0) begin
            errors++;
            $display("FAIL stall_overrun: %0d cycles with >2 outstanding, required 0", ovr_err);
        end
        checks++;
        if (done_cnt != 1) begin
            errors++;
            $display("FAIL stall_done: done pulses=%0d, required 1", done_cnt);
        end
    endtask

    task automatic test_hold();
        bit seen = 0;
        clear_mon();
        out_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            if (out_valid === 1'b1) seen = 1;
            else tick();
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL hold_valid: out_valid never rose, required within 20 cycles");
        end
        repeat (10) tick();
        checks++;
        if (reads < 1 || reads > 2) begin
            errors++;
            $display("FAIL hold_reads: %0d reads while blocked, required 1..2", reads);
        end
        checks++;
        if ({out_valid, out_pixel, out_x, out_y} !== {1'b1, DW'(0), 2'd0, 2'd0} || accepts != 0) begin
            errors++;
            $display("FAIL hold_head: valid=%b pixel=%0d x=%0d y=%0d accepts=%0d, required 1 0 0 0 0",
                     out_valid, out_pixel, out_x, out_y, accepts);
        end
        finish_frame(0);
        checks++;
        if (accepts != N) begin
            errors++;
            $display("FAIL hold_count: got %0d pixels, required %0d", accepts, N);
        end
        for (int i = 0; i < N && i < accepts; i++) begin
            checks++;
            if ({got_pix[i], got_x[i], got_y[i]} !== {DW'(i), 2'(i % W), 2'(i / W)}) begin
                errors++;
                $display("FAIL hold_pix[%0d]: got pixel=%0d x=%0d y=%0d, required %0d (%0d,%0d)",
                         i, got_pix[i], got_x[i], got_y[i], i, i % W, i / W);
            end
        end
    endtask

    task automatic test_start_ignored();
        bit fin = 0;
        clear_mon();
        out_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        // re-pulse start mid-frame, then again during the DONE cycle
        for (int k = 0; k < 400 && !fin; k++) begin
            start = (k == 5) || (done === 1'b1);
            if (done === 1'b1) fin = 1;
            tick();
        end
        start = 1'b0;
        checks++;
        if (!fin) begin
            errors++;
            $display("FAIL ignore_timeout: done never seen, required within 400 cycles");
        end
        repeat (10) tick();
        checks++;
        if (busy !== 1'b0 || accepts != N || reads != N || done_cnt != 1) begin
            errors++;
            $display("FAIL ignore_start: busy=%b accepts=%0d reads=%0d done=%0d, required 0 %0d %0d 1",
                     busy, accepts, reads, done_cnt, N, N);
        end
        run_frame(0);
        checks++;
        if (accepts != N || done_cnt != 1) begin
            errors++;
            $display("FAIL second_count: got %0d pixels %0d dones, required %0d and 1",
                     accepts, done_cnt, N);
        end
        for (int i = 0; i < N && i < accepts; i++) begin
            checks++;
            if ({got_pix[i], got_x[i], got_y[i]} !== {DW'(i), 2'(i % W), 2'(i / W)}) begin
                errors++;
                $display("FAIL second_pix[%0d]: got pixel=%0d x=%0d y=%0d, required %0d (%0d,%0d)",
                         i, got_pix[i], got_x[i], got_y[i], i, i % W, i / W);
            end
        end
    endtask

    task automatic test_mid_reset();
        bit hit = 0;
        clear_mon();
        out_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 40 && !hit; k++) begin
            if (out_valid === 1'b1 && out_pixel === DW'(7)) hit = 1;
            else tick();
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL midrst_reach: pixel 7 never presented, required within 40 cycles");
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, mem_rd_en, out_valid, mem_rd_addr, out_pixel, out_x, out_y} !== '0) begin
            errors++;
            $display("FAIL midrst_outputs: busy=%b done=%b rd_en=%b valid=%b addr=%0d pixel=%0d x=%0d y=%0d, required all 0",
                     busy, done, mem_rd_en, out_valid, mem_rd_addr, out_pixel, out_x, out_y);
        end
        repeat (3) tick();
        rst = 1'b0;
        repeat (5) tick();
        checks++;
        if (done_cnt != 0) begin
            errors++;
            $display("FAIL midrst_done: %0d done pulses after abort, required 0", done_cnt);
        end
        run_frame(0);
        checks++;
        if (first_rd_addr != 0 || accepts != N) begin
            errors++;
            $display("FAIL midrst_restart: first addr=%0d pixels=%0d, required 0 and %0d",
                     first_rd_addr, accepts, N);
        end
        for (int i = 0; i < N && i < accepts; i++) begin
            checks++;
            if ({got_pix[i], got_x[i], got_y[i]} !== {DW'(i), 2'(i % W), 2'(i / W)}) begin
                errors++;
                $display("FAIL midrst_pix[%0d]: got pixel=%0d x=%0d y=%0d, required %0d (%0d,%0d)",
                         i, got_pix[i], got_x[i], got_y[i], i, i % W, i / W);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) mem[i] = DW'(i);
        test_reset();
        test_stream();
        test_random_stall();
        test_hold();
        test_start_ignored();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
